lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 54 +++++
 rtl/lsu.sv | 246 ++++++++++++++++++++++++
 tb/tb_lsu.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// LSU port bundle: pipeline request/response handshake plus the memory bus.
// The LSU connects through the slave modport; whatever drives requests and
// models the bus uses the master modport.
interface lsu_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
);
  // Pipeline request side
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [3:0]             req_op_i;
  logic                   req_we_i;
  logic [ADDR_WIDTH-1:0]  req_addr_i;
  logic [31:0]            req_wdata_i;
  logic [RADDR_WIDTH-1:0] req_rd_i;

  // Completion back to the pipeline
  logic                   rsp_valid_o;
  logic                   rsp_we_o;
  logic [RADDR_WIDTH-1:0] rsp_rd_o;
  logic [31:0]            rsp_rdata_o;
  logic                   rsp_misalign_o;
  logic                   rsp_buserr_o;
  logic                   stall_o;

  // Memory bus
  logic                   bus_valid_o;
  logic                   bus_ready_i;
  logic [ADDR_WIDTH-1:0]  bus_addr_o;
  logic                   bus_we_o;
  logic [3:0]             bus_be_o;
  logic [31:0]            bus_wdata_o;
  logic                   bus_rvalid_i;
  logic                   bus_err_i;
  logic [31:0]            bus_rdata_i;

  modport slave (
    input  req_valid_i, req_op_i, req_we_i, req_addr_i, req_wdata_i, req_rd_i,
    input  bus_ready_i, bus_rvalid_i, bus_err_i, bus_rdata_i,
    output req_ready_o,
    output rsp_valid_o, rsp_we_o, rsp_rd_o, rsp_rdata_o, rsp_misalign_o, rsp_buserr_o,
    output stall_o,
    output bus_valid_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );

  modport master (
    output req_valid_i, req_op_i, req_we_i, req_addr_i, req_wdata_i, req_rd_i,
    output bus_ready_i, bus_rvalid_i, bus_err_i, bus_rdata_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_we_o, rsp_rd_o, rsp_rdata_o, rsp_misalign_o, rsp_buserr_o,
    input  stall_o,
    input  bus_valid_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one memory request at a time from the pipeline,
// issues a single word-aligned bus command (byte enables + lane-replicated
// store data), waits for the read/write response and returns a one-cycle
// completion with sign/zero-extended load data or an exception flag.
// Misaligned halfword/word accesses complete without touching the bus.
//
// Optional feature: define LSU_TIMEOUT_EN to add a 16-bit bus-wait counter;
// after TIMEOUT_CYCLES cycles in CMD/WAIT the access is forced to complete
// with rsp_buserr_o set. Without it the unit waits on the bus indefinitely.
module lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  lsu_if.slave  io
);

  // Operation encodings shared with the decoder.
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // A bad timeout value is a build error rather than a silent wrap.
  generate
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("lsu: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  // Halfword accesses need addr[0]=0, word accesses addr[1:0]=0.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return (a != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by the access; loads always read the whole word.
  function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_SB:  return 4'b0001 << a;
      MEM_SH:  return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated into every lane so the bus needs no shifter.
  function automatic logic [31:0] lane_data(input logic [3:0] op, input logic [31:0] w);
    case (op)
      MEM_SB:  return {4{w[7:0]}};
      MEM_SH:  return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Pull the addressed byte/halfword down to bit 0 and extend it.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (op)
      MEM_LB:  return {{24{sh[7]}}, sh[7:0]};
      MEM_LBU: return {24'h0, sh[7:0]};
      MEM_LH:  return {{16{sh[15]}}, sh[15:0]};
      MEM_LHU: return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  state_t                 state_reg,    state_next;
  logic [3:0]             op_reg,       op_next;
  logic                   we_reg,       we_next;
  logic [ADDR_WIDTH-1:0]  addr_reg,     addr_next;
  logic [31:0]            wdata_reg,    wdata_next;
  logic [RADDR_WIDTH-1:0] rd_reg,       rd_next;
  logic [31:0]            rdata_reg,    rdata_next;
  logic                   misalign_reg, misalign_next;
  logic                   buserr_reg,   buserr_next;
  // Holds req_ready_o low while in reset and until the first edge after it.
  logic                   live_reg;

  logic                   req_ready;
  logic                   bus_valid;
  logic                   rsp_valid;
  logic                   rsp_we;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]            cnt_reg, cnt_next;
`endif

  // Next-state and datapath update for the IDLE/CMD/WAIT/DONE sequence.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rd_next       = rd_reg;
    rdata_next    = rdata_reg;
    misalign_next = misalign_reg;
    buserr_next   = buserr_reg;
`ifdef LSU_TIMEOUT_EN
    cnt_next      = cnt_reg;
`endif
    req_ready     = 1'b0;
    bus_valid     = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = live_reg;
        // A NOP is consumed here and produces no response.
        if (live_reg && io.req_valid_i && (io.req_op_i != MEM_NOP)) begin
          op_next       = io.req_op_i;
          we_next       = io.req_we_i;
          addr_next     = io.req_addr_i;
          wdata_next    = io.req_wdata_i;
          rd_next       = io.req_rd_i;
          rdata_next    = '0;
          buserr_next   = 1'b0;
          misalign_next = misaligned(io.req_op_i, io.req_addr_i[1:0]);
          state_next    = misalign_next ? DONE : CMD;
`ifdef LSU_TIMEOUT_EN
          cnt_next      = '0;
`endif
        end
      end

      CMD: begin
        bus_valid = 1'b1;
`ifdef LSU_TIMEOUT_EN
        cnt_next  = cnt_reg + 16'd1;
`endif
        if (io.bus_ready_i) begin
          state_next = WAIT;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_reg >= TIMEOUT_LAST) begin
          state_next  = DONE;
          buserr_next = 1'b1;
`endif
        end
      end

      WAIT: begin
`ifdef LSU_TIMEOUT_EN
        cnt_next = cnt_reg + 16'd1;
`endif
        if (io.bus_rvalid_i) begin
          state_next  = DONE;
          buserr_next = io.bus_err_i;
          rdata_next  = (io.bus_err_i || we_reg) ? '0
                                                 : load_extract(op_reg, addr_reg[1:0], io.bus_rdata_i);
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_reg >= TIMEOUT_LAST) begin
          state_next  = DONE;
          buserr_next = 1'b1;
          rdata_next  = '0;
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and request/response registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      op_reg       <= MEM_NOP;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_reg       <= '0;
      rdata_reg    <= '0;
      misalign_reg <= 1'b0;
      buserr_reg   <= 1'b0;
      live_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rd_reg       <= rd_next;
      rdata_reg    <= rdata_next;
      misalign_reg <= misalign_next;
      buserr_reg   <= buserr_next;
      live_reg     <= 1'b1;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Bus-wait counter, cleared when a command is launched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`endif

  assign rsp_valid = (state_reg == DONE);
  assign rsp_we    = rsp_valid && !we_reg && !misalign_reg && !buserr_reg;

  assign io.req_ready_o    = req_ready;
  assign io.stall_o        = (state_reg != IDLE);

  // Command fields are held from registers, so they stay stable until accepted.
  assign io.bus_valid_o    = bus_valid;
  assign io.bus_addr_o     = bus_valid ? {addr_reg[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign io.bus_we_o       = bus_valid && we_reg;
  assign io.bus_be_o       = bus_valid ? byte_enable(op_reg, addr_reg[1:0]) : 4'b0000;
  assign io.bus_wdata_o    = bus_valid ? lane_data(op_reg, wdata_reg) : '0;

  assign io.rsp_valid_o    = rsp_valid;
  assign io.rsp_we_o       = rsp_we;
  assign io.rsp_rd_o       = rsp_valid ? rd_reg : '0;
  assign io.rsp_rdata_o    = rsp_we ? rdata_reg : '0;
  assign io.rsp_misalign_o = rsp_valid && misalign_reg;
  assign io.rsp_buserr_o   = rsp_valid && buserr_reg;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: a vector table of single accesses (with a simple bus
// responder), plus hand-written sequences for latency, bus stalls/timeout
// and reset in the middle of an access. Expected responses are queued when a
// request is driven and checked by a monitor when rsp_valid_o fires.
module tb_lsu;
  localparam int AW = 32;
  localparam int RW = 5;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(AW), .RADDR_WIDTH(RW)) io ();

  lsu #(.ADDR_WIDTH(AW), .RADDR_WIDTH(RW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (io)
  );

  typedef struct {
    logic [3:0]  op;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          dly;
    logic        exp_bus;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic        exp_mis;
    logic        exp_berr;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        we;
    logic        mis;
    logic        berr;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[17];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Response monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (io.rsp_valid_o === 1'b1) begin
      check("rsp_expected", 128'(exp_q.size() > 0), 128'(1'b1));
      if (exp_q.size() > 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp", 128'({io.rsp_rd_o, io.rsp_rdata_o, io.rsp_we_o, io.rsp_misalign_o, io.rsp_buserr_o}),
              128'({e.rd, e.rdata, e.we, e.mis, e.berr}));
        $display("rsp rd=%0d rdata=%08h we=%0b mis=%0b berr=%0b", io.rsp_rd_o, io.rsp_rdata_o,
                 io.rsp_we_o, io.rsp_misalign_o, io.rsp_buserr_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    for (int i = 0; i < 50 && io.req_ready_o !== 1'b1; i++) @(negedge clk);
    check("req_ready", 128'(io.req_ready_o), 128'(1'b1));
  endtask

  task automatic drive_req(input logic [3:0] op, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
    io.req_valid_i = 1'b1;
    io.req_op_i    = op;
    io.req_we_i    = we;
    io.req_addr_i  = addr;
    io.req_wdata_i = wdata;
    io.req_rd_i    = rd;
  endtask

  task automatic apply(input vec_t v, input int idx);
    wait_ready();
    drive_req(v.op, v.we, v.addr, v.wdata, v.rd);
    if (v.op != OP_NOP) begin
      rsp_t e;
      e.rd = v.rd; e.rdata = v.exp_rdata; e.we = v.exp_we; e.mis = v.exp_mis; e.berr = v.exp_berr;
      exp_q.push_back(e);
    end
    $display("txn %0d op=%0d addr=%08h wdata=%08h", idx, v.op, v.addr, v.wdata);
    @(negedge clk);
    io.req_valid_i = 1'b0;
    if (v.op == OP_NOP) begin
      check($sformatf("v%0d_nop_idle", idx), 128'({io.stall_o, io.bus_valid_o, io.req_ready_o}),
            128'(3'b001));
    end else if (!v.exp_bus) begin
      check($sformatf("v%0d_mis_t1", idx), 128'({io.rsp_valid_o, io.bus_valid_o}), 128'(2'b10));
    end else begin
      check($sformatf("v%0d_cmd", idx),
            128'({io.bus_valid_o, io.stall_o, io.bus_we_o, io.bus_be_o, io.bus_addr_o, io.bus_wdata_o}),
            128'({1'b1, 1'b1, v.we, v.exp_be, v.exp_baddr, v.exp_bwdata}));
      for (int k = 0; k < v.dly; k++) begin
        // A stray response strobe while the command is pending must be ignored.
        io.bus_rvalid_i = (k == 0);
        io.bus_rdata_i  = 32'hBAD0BAD0;
        @(negedge clk);
        io.bus_rvalid_i = 1'b0;
        check($sformatf("v%0d_hold", idx), 128'({io.bus_valid_o, io.stall_o, io.bus_be_o, io.bus_addr_o}),
              128'({1'b1, 1'b1, v.exp_be, v.exp_baddr}));
      end
      io.bus_ready_i = 1'b1;
      @(negedge clk);
      io.bus_ready_i = 1'b0;
      check($sformatf("v%0d_wait", idx), 128'({io.bus_valid_o, io.stall_o}), 128'(2'b01));
      io.bus_rvalid_i = 1'b1;
      io.bus_rdata_i  = v.rdata;
      io.bus_err_i    = v.err;
      @(negedge clk);
      io.bus_rvalid_i = 1'b0;
      io.bus_err_i    = 1'b0;
    end
  endtask

  initial begin
    io.req_valid_i  = 1'b0;
    io.req_op_i     = OP_NOP;
    io.req_we_i     = 1'b0;
    io.req_addr_i   = '0;
    io.req_wdata_i  = '0;
    io.req_rd_i     = '0;
    io.bus_ready_i  = 1'b0;
    io.bus_rvalid_i = 1'b0;
    io.bus_err_i    = 1'b0;
    io.bus_rdata_i  = '0;

    //          op      we    addr          wdata         rd     bus rdata     err  dly bus   bus addr      be       bus wdata     rsp rdata     we    mis   berr
    vecs[0]  = '{OP_LW,  1'b0, 32'h00000100, 32'h00000000, 5'd1,  32'hDEADBEEF, 1'b0, 0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OP_LB,  1'b0, 32'h00000103, 32'h00000000, 5'd2,  32'h80112233, 1'b0, 1, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_LBU, 1'b0, 32'h00000103, 32'h00000000, 5'd3,  32'h80112233, 1'b0, 0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'h00000080, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_LH,  1'b0, 32'h00000102, 32'h00000000, 5'd4,  32'h80112233, 1'b0, 0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'hFFFF8011, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{OP_LHU, 1'b0, 32'h00000100, 32'h00000000, 5'd5,  32'h80118233, 1'b0, 0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'h00008233, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{OP_LB,  1'b0, 32'h00000101, 32'h00000000, 5'd6,  32'h80112233, 1'b0, 0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'h00000022, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{OP_SH,  1'b1, 32'h00000022, 32'h0000ABCD, 5'd7,  32'h12345678, 1'b0, 0, 1'b1, 32'h00000020, 4'hC, 32'hABCDABCD, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_SB,  1'b1, 32'h00000041, 32'h000000A5, 5'd8,  32'h00000000, 1'b0, 2, 1'b1, 32'h00000040, 4'h2, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SW,  1'b1, 32'h00000080, 32'h12345678, 5'd9,  32'h00000000, 1'b0, 0, 1'b1, 32'h00000080, 4'hF, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_LW,  1'b0, 32'h00000200, 32'h00000000, 5'd10, 32'h55555555, 1'b1, 0, 1'b1, 32'h00000200, 4'hF, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{OP_LW,  1'b0, 32'h00000102, 32'h00000000, 5'd11, 32'h00000000, 1'b0, 0, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{OP_LH,  1'b0, 32'h00000101, 32'h00000000, 5'd12, 32'h00000000, 1'b0, 0, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_SW,  1'b1, 32'h00000081, 32'hCAFEF00D, 5'd13, 32'h00000000, 1'b0, 0, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{OP_NOP, 1'b0, 32'h00000000, 32'h00000000, 5'd14, 32'h00000000, 1'b0, 0, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_LH,  1'b0, 32'h00000106, 32'h00000000, 5'd15, 32'h7FFF0000, 1'b0, 3, 1'b1, 32'h00000104, 4'hF, 32'h00000000, 32'h00007FFF, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{OP_SB,  1'b1, 32'h00000043, 32'h123456C3, 5'd16, 32'h00000000, 1'b0, 0, 1'b1, 32'h00000040, 4'h8, 32'hC3C3C3C3, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{OP_LHU, 1'b0, 32'h00000102, 32'h00000000, 5'd17, 32'hFFFE1234, 1'b0, 0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 32'h0000FFFE, 1'b1, 1'b0, 1'b0};

    // Reset state: everything low, including req_ready_o.
    #2;
    check("reset_outputs",
          128'({io.req_ready_o, io.stall_o, io.bus_valid_o, io.bus_we_o, io.bus_be_o,
                io.rsp_valid_o, io.rsp_we_o, io.rsp_misalign_o, io.rsp_buserr_o}),
          128'(12'h000));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(io.req_ready_o), 128'(1'b1));

    // Stray response strobe while idle produces nothing.
    io.bus_rvalid_i = 1'b1;
    @(negedge clk);
    io.bus_rvalid_i = 1'b0;
    check("idle_rvalid_ignored", 128'({io.rsp_valid_o, io.stall_o, io.req_ready_o}), 128'(3'b001));

    // Minimum latency: accept T, bus ready T+1, rvalid T+2, response T+3.
    wait_ready();
    drive_req(OP_LW, 1'b0, 32'h00000100, 32'h0, 5'd20);
    begin
      rsp_t e;
      e.rd = 5'd20; e.rdata = 32'hDEADBEEF; e.we = 1'b1; e.mis = 1'b0; e.berr = 1'b0;
      exp_q.push_back(e);
    end
    $display("txn lat LW addr=00000100");
    @(negedge clk);
    io.req_valid_i = 1'b0;
    check("lat_t1", 128'({io.rsp_valid_o, io.bus_valid_o}), 128'(2'b01));
    io.bus_ready_i = 1'b1;
    @(negedge clk);
    io.bus_ready_i = 1'b0;
    check("lat_t2", 128'({io.rsp_valid_o, io.bus_valid_o}), 128'(2'b00));
    io.bus_rvalid_i = 1'b1;
    io.bus_rdata_i  = 32'hDEADBEEF;
    @(negedge clk);
    io.bus_rvalid_i = 1'b0;
    check("lat_t3", 128'({io.rsp_valid_o, io.stall_o}), 128'(2'b11));
    @(negedge clk);
    check("lat_t4_pulse", 128'({io.rsp_valid_o, io.stall_o, io.req_ready_o}), 128'(3'b001));

    // Table-driven single accesses.
    for (int i = 0; i < 17; i++) apply(vecs[i], i);

`ifdef LSU_TIMEOUT_EN
    // Bus never accepts: forced completion with a bus error after TMO cycles.
    wait_ready();
    drive_req(OP_LW, 1'b0, 32'h00000400, 32'h0, 5'd21);
    begin
      rsp_t e;
      e.rd = 5'd21; e.rdata = 32'h0; e.we = 1'b0; e.mis = 1'b0; e.berr = 1'b1;
      exp_q.push_back(e);
    end
    $display("txn timeout LW addr=00000400");
    begin
      int k;
      k = 0;
      while (k < 20 && io.rsp_valid_o !== 1'b1) begin
        @(negedge clk);
        io.req_valid_i = 1'b0;
        k++;
      end
      check("timeout_latency", 128'(k), 128'(TMO + 1));
    end
    @(negedge clk);
    check("timeout_release", 128'({io.stall_o, io.bus_valid_o, io.req_ready_o}), 128'(3'b001));
`else
    // Without the timeout the unit waits on the bus for as long as it takes.
    begin
      vec_t v;
      v = '{OP_LW, 1'b0, 32'h00000500, 32'h0, 5'd22, 32'h0BADF00D, 1'b0, 20, 1'b1,
            32'h00000500, 4'hF, 32'h0, 32'h0BADF00D, 1'b1, 1'b0, 1'b0};
      apply(v, 100);
    end
`endif

    // Reset during WAIT: access abandoned, a late response is ignored.
    wait_ready();
    drive_req(OP_LW, 1'b0, 32'h00000300, 32'h0, 5'd3);
    $display("txn reset-mid LW addr=00000300");
    @(negedge clk);
    io.req_valid_i = 1'b0;
    io.bus_ready_i = 1'b1;
    @(negedge clk);
    io.bus_ready_i = 1'b0;
    check("rst_mid_in_wait", 128'({io.stall_o, io.bus_valid_o}), 128'(2'b10));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 128'({io.req_ready_o, io.stall_o, io.bus_valid_o, io.rsp_valid_o}), 128'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    io.bus_rvalid_i = 1'b1;
    io.bus_rdata_i  = 32'h11111111;
    @(negedge clk);
    io.bus_rvalid_i = 1'b0;
    check("rst_release", 128'({io.req_ready_o, io.rsp_valid_o, io.stall_o}), 128'(3'b100));
    @(negedge clk);
    check("rst_no_rsp", 128'({io.req_ready_o, io.rsp_valid_o}), 128'(2'b10));

    repeat (3) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
